// File: rtl/logs_voice.sv
`default_nettype none
// ============================================================================
// Module   : logs_voice
// Purpose  : Single square-wave voice. Queued note commands (period, duty,
//            length) become a registered 1-bit audio line. One note plays
//            while a 1-deep pending slot holds the next, so back-to-back notes
//            switch with no idle cycle. Note lengths count the tick strobe.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            tick           - length timebase strobe (one clk wide)
//            cmd_valid/ready- note command handshake (ready is combinational)
//            cmd_period     - tone period in clk cycles, 0 = rest
//            cmd_duty       - 0=12.5% 1=25% 2=50% 3=75%
//            cmd_length     - length in ticks, 0 = sustain until next note
//            cmd_sweep      - (LOGS_VOICE_SWEEP_EN only) bit3 down, bits2:0 shift
//            busy           - a note is playing
//            audio_out      - registered square wave
// Config   : define LOGS_VOICE_SWEEP_EN to add the per-tick period sweep.
// Revision : 1.0 - initial release
// ============================================================================
module logs_voice #(
  parameter int PW = 12,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [PW-1:0] cmd_period,
  input  logic [1:0]    cmd_duty,
  input  logic [LW-1:0] cmd_length,
`ifdef LOGS_VOICE_SWEEP_EN
  input  logic [3:0]    cmd_sweep,
`endif
  output logic          busy,
  output logic          audio_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [1:0]    duty_q, duty_d;
  logic [LW-1:0] len_q, len_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          pend_valid_q, pend_valid_d;
  logic [PW-1:0] pend_period_q, pend_period_d;
  logic [1:0]    pend_duty_q, pend_duty_d;
  logic [LW-1:0] pend_len_q, pend_len_d;
  logic          audio_q, audio_d;
`ifdef LOGS_VOICE_SWEEP_EN
  logic [3:0]    sweep_q, sweep_d;
  logic [3:0]    pend_sweep_q, pend_sweep_d;
  logic [PW-1:0] sweep_delta;
  logic [PW:0]   sweep_sum;
`endif

  logic          accept;
  logic          note_end;
  logic [PW-1:0] thr;
  logic [PW:0]   cnt_inc;

  assign cmd_ready = !reset && (state_q == S_IDLE || !pend_valid_q);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q == S_PLAY);
  assign audio_out = audio_q;

  always_comb begin
    thr      = '0;
    note_end = 1'b0;
    // Computed one bit wider so the wrap test also covers cnt >= period
    // (period 0, or a period that a sweep step pulled below cnt).
    cnt_inc  = {1'b0, cnt_q} + {{PW{1'b0}}, 1'b1};

    state_d       = state_q;
    period_d      = period_q;
    duty_d        = duty_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    pend_len_d    = pend_len_q;
    audio_d       = 1'b0;
`ifdef LOGS_VOICE_SWEEP_EN
    sweep_d      = sweep_q;
    pend_sweep_d = pend_sweep_q;
    sweep_delta  = period_q >> sweep_q[2:0];
    sweep_sum    = {1'b0, period_q} + {1'b0, sweep_delta};
`endif

    case (duty_q)
      2'd0:    thr = period_q >> 3;
      2'd1:    thr = period_q >> 2;
      2'd2:    thr = period_q >> 1;
      default: thr = period_q - (period_q >> 2);
    endcase

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_PLAY;
          period_d = cmd_period;
          duty_d   = cmd_duty;
          len_d    = cmd_length;
          cnt_d    = '0;
`ifdef LOGS_VOICE_SWEEP_EN
          sweep_d  = cmd_sweep;
`endif
        end
      end
      default: begin
        note_end = tick && ((len_q == LW'(1)) || (len_q == '0 && pend_valid_q));
        cnt_d    = (cnt_inc >= {1'b0, period_q}) ? '0 : cnt_q + PW'(1);

        if (tick && !note_end) begin
          if (len_q > LW'(1)) begin
            len_d = len_q - LW'(1);
          end
`ifdef LOGS_VOICE_SWEEP_EN
          if (sweep_q[2:0] != 3'd0) begin
            if (sweep_q[3]) begin
              period_d = period_q - sweep_delta;
            end else begin
              period_d = sweep_sum[PW] ? {PW{1'b1}} : sweep_sum[PW-1:0];
            end
          end
`endif
        end

        if (note_end) begin
          cnt_d = '0;
          if (pend_valid_q) begin
            period_d     = pend_period_q;
            duty_d       = pend_duty_q;
            len_d        = pend_len_q;
            pend_valid_d = 1'b0;
`ifdef LOGS_VOICE_SWEEP_EN
            sweep_d      = pend_sweep_q;
`endif
          end else if (accept) begin
            // Slot was empty, so a command arriving on the ending tick
            // goes straight to the active note.
            period_d = cmd_period;
            duty_d   = cmd_duty;
            len_d    = cmd_length;
`ifdef LOGS_VOICE_SWEEP_EN
            sweep_d  = cmd_sweep;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else if (accept) begin
          pend_valid_d  = 1'b1;
          pend_period_d = cmd_period;
          pend_duty_d   = cmd_duty;
          pend_len_d    = cmd_length;
`ifdef LOGS_VOICE_SWEEP_EN
          pend_sweep_d  = cmd_sweep;
`endif
        end
      end
    endcase

    // Gating on state_d silences the line in the same cycle busy drops.
    audio_d = (state_q == S_PLAY) && (state_d == S_PLAY) &&
              (period_q != '0) && (cnt_q < thr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      period_q      <= '0;
      duty_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      pend_valid_q  <= 1'b0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_len_q    <= '0;
      audio_q       <= 1'b0;
`ifdef LOGS_VOICE_SWEEP_EN
      sweep_q       <= '0;
      pend_sweep_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      duty_q        <= duty_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_len_q    <= pend_len_d;
      audio_q       <= audio_d;
`ifdef LOGS_VOICE_SWEEP_EN
      sweep_q       <= sweep_d;
      pend_sweep_q  <= pend_sweep_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logs_voice.sv
`default_nettype none
// ============================================================================
// Module   : tb_logs_voice
// Purpose  : Self-checking bench for logs_voice: table of single sustained
//            notes checked through an expected-audio queue, plus hand-written
//            sequences for length, queueing, rests, sustain and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logs_voice;
  localparam int PW = 12;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [PW-1:0] cmd_period = '0;
  logic [1:0]    cmd_duty = '0;
  logic [LW-1:0] cmd_length = '0;
  logic [3:0]    cmd_sweep = '0;
  logic          busy;
  logic          audio_out;

  int checks = 0;
  int failures = 0;
  bit exp_q[$];

  logs_voice #(.PW(PW), .LW(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_period(cmd_period),
    .cmd_duty  (cmd_duty),
    .cmd_length(cmd_length),
`ifdef LOGS_VOICE_SWEEP_EN
    .cmd_sweep (cmd_sweep),
`endif
    .busy      (busy),
    .audio_out (audio_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] period;
    logic [1:0]    duty;
    int            thr;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic sb_pop(input string name);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty at %0t", name, $time);
    end else begin
      chk(name, audio_out, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    step(0);
    step(0);
    chk("rst_busy", busy, 0);
    chk("rst_audio", audio_out, 0);
    chk("rst_ready_in_reset", cmd_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", cmd_ready, 1);
  endtask

  task automatic offer(input int p, input int d, input int l);
    cmd_period = PW'(p);
    cmd_duty   = 2'(d);
    cmd_length = LW'(l);
    cmd_valid  = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit e;
    int n;
    vecs[0] = '{12'd8,   2'd2, 4};
    vecs[1] = '{12'd16,  2'd0, 2};
    vecs[2] = '{12'd16,  2'd3, 12};
    vecs[3] = '{12'd12,  2'd1, 3};
    vecs[4] = '{12'd7,   2'd0, 0};
    vecs[5] = '{12'd0,   2'd2, 0};
    vecs[6] = '{12'd10,  2'd3, 8};
    vecs[7] = '{12'd100, 2'd1, 25};
    vecs[8] = '{12'd9,   2'd1, 2};

    // Table: sustained notes, waveform expected from the hand-derived threshold.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      offer(int'(vecs[v].period), int'(vecs[v].duty), 0);
      chk("tbl_ready", cmd_ready, 1);
      step(0);
      cmd_valid = 1'b0;
      chk("tbl_busy_k1", busy, 1);
      n = (vecs[v].period == 0) ? 16 : 2 * int'(vecs[v].period);
      for (int i = 0; i < n; i++) begin
        if (vecs[v].period == 0) e = 1'b0;
        else e = ((i % int'(vecs[v].period)) < vecs[v].thr);
        exp_q.push_back(e);
        step(0);
        sb_pop("tbl_audio");
      end
    end

    // Seq 1: period 8, 50%, length 2, tick every 64 clk.
    do_reset();
    offer(8, 2, 2);
    step(0);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      exp_q.push_back((k <= 127) ? (((k - 1) % 8) < 4) : 1'b0);
      step(k == 64 || k == 128);
      sb_pop("s1_audio");
      chk("s1_busy", busy, (k < 128) ? 1 : 0);
    end

    // Seq 2: A plays, B pends, C stalls until B is promoted.
    do_reset();
    offer(8, 2, 1);
    step(0);                         // A accepted
    offer(16, 0, 1);
    chk("s2_b_ready", cmd_ready, 1);
    step(0);                         // B into pending
    offer(12, 1, 1);
    chk("s2_c_stall", cmd_ready, 0);
    for (int k = 2; k <= 9; k++) begin
      step(0);
      chk("s2_c_stall_hold", cmd_ready, 0);
    end
    step(1);                         // A ends, B loaded
    chk("s2_no_gap_busy", busy, 1);
    chk("s2_slot_free", cmd_ready, 1);
    step(0);                         // C accepted
    cmd_valid = 1'b0;
    chk("s2_c_pending", cmd_ready, 0);
    chk("s2_b_cnt0", audio_out, 1);
    step(0);
    chk("s2_b_cnt1", audio_out, 1);
    step(0);
    chk("s2_b_cnt2", audio_out, 0);
    for (int k = 14; k <= 19; k++) step(0);
    step(1);                         // B ends, C loaded
    chk("s2_c_busy", busy, 1);
    chk("s2_c_ready", cmd_ready, 1);
    step(0);
    chk("s2_c_cnt0", audio_out, 1);
    for (int k = 22; k <= 29; k++) step(0);
    step(1);                         // C ends, nothing queued
    chk("s2_end_busy", busy, 0);
    chk("s2_end_audio", audio_out, 0);

    // Seq 3: rest of 3 ticks.
    do_reset();
    offer(0, 2, 3);
    step(0);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      step(k == 10 || k == 20 || k == 30);
      chk("s3_audio", audio_out, 0);
      chk("s3_busy", busy, (k < 30) ? 1 : 0);
    end

    // Seq 4: sustain, then switch at the next tick after queueing.
    do_reset();
    offer(16, 0, 0);
    step(0);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      exp_q.push_back(((k - 1) % 16) < 2);
      step(k == 40);
      sb_pop("s4_sustain_audio");
    end
    chk("s4_sustain_busy", busy, 1);
    offer(8, 3, 1);
    step(0);
    cmd_valid = 1'b0;
    chk("s4_queued", cmd_ready, 0);
    for (int k = 42; k <= 49; k++) step(0);
    step(1);
    chk("s4_switch_busy", busy, 1);
    for (int k = 51; k <= 66; k++) begin
      exp_q.push_back(((k - 51) % 8) < 6);
      step(0);
      sb_pop("s4_new_audio");
    end
    for (int k = 67; k <= 70; k++) step(k == 70);
    chk("s4_end_busy", busy, 0);

    // Seq 5: reset mid-note with pending full.
    do_reset();
    offer(8, 3, 0);
    step(0);
    offer(8, 2, 0);
    step(0);
    cmd_valid = 1'b0;
    chk("s5_pend_full", cmd_ready, 0);
    step(0);
    step(0);
    chk("s5_audio_before", audio_out, 1);
    reset = 1'b1;
    step(0);
    chk("s5_audio_reset", audio_out, 0);
    chk("s5_busy_reset", busy, 0);
    reset = 1'b0;
    #1;
    chk("s5_ready_after", cmd_ready, 1);
    for (int k = 0; k < 20; k++) begin
      step(k % 5 == 4);
      chk("s5_no_pending_play", busy, 0);
      chk("s5_silent", audio_out, 0);
    end

`ifdef LOGS_VOICE_SWEEP_EN
    // Seq 6: sweep up from 64 with shift 2, then down from 1 with shift 1.
    do_reset();
    cmd_sweep = 4'b0010;
    offer(64, 2, 0);
    step(0);
    cmd_valid = 1'b0;
    step(0);
    step(1);
    chk("s6_up1", dut.period_q, 80);
    step(0);
    step(1);
    chk("s6_up2", dut.period_q, 100);
    do_reset();
    cmd_sweep = 4'b1001;
    offer(1, 2, 0);
    step(0);
    cmd_valid = 1'b0;
    step(1);
    chk("s6_down1", dut.period_q, 1);
    step(1);
    chk("s6_down2", dut.period_q, 1);
    cmd_sweep = 4'b0000;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
